// File: rtl/corral_input_cond_if.sv
// Corral input-conditioner bus: raw pad inputs and busy in, clean move/enter out.
// master = the pads/game side driving raw inputs; slave = the conditioner.
interface corral_input_cond_if;
    logic [2:0] btn_move;
    logic       btn_enter;
    logic       busy;
    logic [2:0] move;
    logic       enter;
    logic       pending;
    logic [3:0] drop_cnt;

    modport master (
        output btn_move, btn_enter, busy,
        input  move, enter, pending, drop_cnt
    );

    modport slave (
        input  btn_move, btn_enter, busy,
        output move, enter, pending, drop_cnt
    );
endinterface

// File: rtl/corral_input_cond.sv
// Corral input stage: synchronises and debounces the move switches and the
// enter button, then turns each enter press into one single-cycle enter pulse
// carrying a stable move code. One press may wait while the game is busy.
// Optional macro CORRAL_DROP_CNT_EN builds a saturating dropped-press counter;
// without it drop_cnt is tied to zero.

// Per-bit conditioner: 2-flop synchroniser followed by a debounce counter.
module corral_db_bit #(
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_db
);
    logic             r_sync1;
    logic             r_sync2;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;

    // Two-flop synchroniser for the asynchronous pad input.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: value only changes after DB_CYCLES consecutive differing samples;
    // any agreeing sample restarts the count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else if (r_sync2 == r_db) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
            r_db  <= ~r_db;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_db = r_db;
endmodule

module corral_input_cond #(
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    corral_input_cond_if.slave   bus
);
    typedef enum logic {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_t;

    logic [3:0] w_raw;
    logic [3:0] w_db;
    logic [2:0] w_db_move;
    logic       w_db_enter;
    logic       w_rise;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_db_prev;
    logic       r_enter;
    logic       w_enter_nxt;
    logic [2:0] r_move;
    logic [2:0] w_move_nxt;

    // Bit 3 is enter, bits 2:0 are the move switches; each conditioned alone.
    assign w_raw = {bus.btn_enter, bus.btn_move};

    corral_db_bit #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_db [3:0] (
        .clock   (clock),
        .reset_n (reset_n),
        .i_raw   (w_raw),
        .o_db    (w_db)
    );

    assign w_db_move  = w_db[2:0];
    assign w_db_enter = w_db[3];
    assign w_rise     = w_db_enter & ~r_db_prev;

    // Previous debounced enter, for rising-edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_db_prev <= 1'b0;
        else          r_db_prev <= w_db_enter;
    end

    // State, registered enter pulse and captured move code.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_enter <= 1'b0;
            r_move  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_enter <= w_enter_nxt;
            r_move  <= w_move_nxt;
        end
    end

    // Capture/issue: a rise in IDLE issues at once or parks while busy; a rise
    // while parked is dropped, even in the cycle the parked press is released.
    always_comb begin
        w_state_nxt = r_state;
        w_enter_nxt = 1'b0;
        w_move_nxt  = r_move;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_move_nxt = w_db_move;
                    if (bus.busy) w_state_nxt = S_PEND;
                    else          w_enter_nxt = 1'b1;
                end
            end
            S_PEND: begin
                if (!bus.busy) begin
                    w_enter_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.enter   = r_enter;
    assign bus.move    = r_move;
    assign bus.pending = (r_state == S_PEND);

`ifdef CORRAL_DROP_CNT_EN
    logic       w_drop;
    logic [3:0] r_drop_cnt;

    assign w_drop = (r_state == S_PEND) & w_rise;

    // Saturating count of presses lost because one was already waiting.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                           r_drop_cnt <= 4'd0;
        else if (w_drop && r_drop_cnt != 4'hF)  r_drop_cnt <= r_drop_cnt + 4'd1;
    end

    assign bus.drop_cnt = r_drop_cnt;
`else
    assign bus.drop_cnt = 4'd0;
`endif
endmodule

// File: tb/tb_corral_input_cond.sv
// Directed bench for corral_input_cond with DB_CYCLES=4.
module tb_corral_input_cond;
    localparam int DB = 4;
`ifdef CORRAL_DROP_CNT_EN
    localparam int EXP_DROP1 = 1;
    localparam int EXP_SAT   = 15;
`else
    localparam int EXP_DROP1 = 0;
    localparam int EXP_SAT   = 0;
`endif

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    corral_input_cond_if bus();

    corral_input_cond #(.DB_CYCLES(DB), .CNT_W(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int n_cmp   = 0;
    int n_err   = 0;
    int n_pulse = 0;

    always @(negedge clock) if (bus.enter === 1'b1) n_pulse++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int p0;
        int first;

        bus.btn_move  = 3'd0;
        bus.btn_enter = 1'b0;
        bus.busy      = 1'b0;
        #1;
        chk("rst_enter",   32'(bus.enter),    0);
        chk("rst_pending", 32'(bus.pending),  0);
        chk("rst_move",    32'(bus.move),     0);
        chk("rst_drop",    32'(bus.drop_cnt), 0);
        idle(3);
        reset_n = 1'b1;
        idle(2);

        // Clean press: rise sampled at edge 0, enter high after edge 6.
        bus.btn_move = 3'b101;
        idle(10);
        p0 = n_pulse;
        first = -1;
        bus.btn_enter = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.enter && first < 0) first = i;
        end
        chk("clean_at",      32'(first), 6);
        chk("clean_npulse",  32'(n_pulse - p0), 1);
        chk("clean_move",    32'(bus.move), 3'b101);
        chk("clean_pending", 32'(bus.pending), 0);
        p0 = n_pulse;
        bus.btn_enter = 1'b0;
        idle(10);
        chk("fall_none", 32'(n_pulse - p0), 0);

        // Bounce 1,0,1,0 then held: final rise at edge 4, enter after edge 10.
        p0 = n_pulse;
        first = -1;
        bus.btn_enter = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.enter && first < 0) first = i;
            bus.btn_enter = (i + 1 >= 4) ? 1'b1 : (((i + 1) % 2) == 0);
        end
        chk("bounce_at",     32'(first), 10);
        chk("bounce_npulse", 32'(n_pulse - p0), 1);
        bus.btn_enter = 1'b0;
        idle(10);

        // Busy hold.
        bus.busy = 1'b1;
        bus.btn_move = 3'b011;
        idle(10);
        p0 = n_pulse;
        bus.btn_enter = 1'b1;
        idle(12);
        chk("hold_pending", 32'(bus.pending), 1);
        chk("hold_move",    32'(bus.move), 3'b011);
        idle(8);
        chk("hold_none",    32'(n_pulse - p0), 0);
        bus.busy = 1'b0;
        tick();
        chk("hold_enter",   32'(bus.enter), 1);
        chk("hold_pend0",   32'(bus.pending), 0);
        chk("hold_move2",   32'(bus.move), 3'b011);
        tick();
        chk("hold_enter1c", 32'(bus.enter), 0);
        bus.btn_enter = 1'b0;
        idle(10);

        // Drop: second press while one is pending is lost.
        bus.busy = 1'b1;
        bus.btn_move = 3'b001;
        idle(10);
        bus.btn_enter = 1'b1;
        idle(10);
        bus.btn_enter = 1'b0;
        bus.btn_move = 3'b110;
        idle(10);
        bus.btn_enter = 1'b1;
        idle(10);
        chk("drop_pending", 32'(bus.pending), 1);
        chk("drop_move",    32'(bus.move), 3'b001);
        p0 = n_pulse;
        bus.busy = 1'b0;
        tick();
        chk("drop_enter",   32'(bus.enter), 1);
        chk("drop_move2",   32'(bus.move), 3'b001);
        idle(10);
        chk("drop_npulse",  32'(n_pulse - p0), 1);
        chk("drop_cnt",     32'(bus.drop_cnt), EXP_DROP1);
        bus.btn_enter = 1'b0;
        idle(10);

        // Saturation: one pending press plus 20 dropped presses.
        bus.busy = 1'b1;
        repeat (21) begin
            bus.btn_enter = 1'b1;
            idle(8);
            bus.btn_enter = 1'b0;
            idle(8);
        end
        chk("sat_drop",    32'(bus.drop_cnt), EXP_SAT);
        chk("sat_pending", 32'(bus.pending), 1);
        chk("sat_move",    32'(bus.move), 3'b110);

        // Reset with a press pending: outputs clear at once, nothing issued later.
        reset_n = 1'b0;
        #1;
        chk("mrst_enter",   32'(bus.enter), 0);
        chk("mrst_pending", 32'(bus.pending), 0);
        chk("mrst_move",    32'(bus.move), 0);
        chk("mrst_drop",    32'(bus.drop_cnt), 0);
        tick();
        reset_n = 1'b1;
        bus.busy = 1'b0;
        p0 = n_pulse;
        idle(20);
        chk("mrst_none",    32'(n_pulse - p0), 0);
        chk("mrst_pend2",   32'(bus.pending), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/corral_input_cond.md
Name: corral_input_cond

Overview:
- Upstream input stage for the Corral game.
- Conditions the raw move switches and enter button from the pads into the clean `move`/`enter` pair that the game top consumes.
- Synchronises and debounces all four inputs, and turns each enter press into exactly one single-cycle `enter` pulse carrying a stable move code.
- Holds one press pending while the game is busy.

Parameters:
- DB_CYCLES, 16: consecutive stable cycles required before a debounced input changes value (legal range 2..65535).
- CNT_W, 16: width of each debounce counter; must hold DB_CYCLES-1.

Ports:
- clock  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- btn_move  input  3  raw asynchronous move switches.
- btn_enter  input  1  raw asynchronous enter button, active high.
- busy  input  1  high while the game top is not in its idle/accepting state.
- move  output  3  move code; stable from the enter pulse until the next capture.
- enter  output  1  one-cycle request pulse to the game top.
- pending  output  1  a captured press is waiting for busy to drop.
- drop_cnt  output  4  dropped-press count; tied to 0 unless CORRAL_DROP_CNT_EN is defined.

Behaviour:
- Reset (asynchronous, reset_n low), all cleared to 0:
  - sync flops, debounced values, debounce counters, db_prev, pending, enter, move, drop_cnt.
  - Deassertion takes effect at the next clock edge.
- Synchroniser: 2-flop chain on each of the 4 raw bits; sync2 is the synchronised value.
- Debounce, one counter per bit, each bit independent:
  - sync2 == db: counter cleared.
  - sync2 != db and counter == DB_CYCLES-1: db toggles and counter clears.
  - Otherwise the counter increments.
  - Any single-cycle glitch therefore restarts the count.
- Rise detect: db_enter & ~db_prev, with db_prev the registered db_enter. Falls and held levels generate nothing.
- Capture and issue, on a rise:
  - pending==0 and busy==0: move <= db_move; enter <= 1 for one cycle; pending stays 0.
  - pending==0 and busy==1: move <= db_move; pending <= 1.
  - pending==1: the press is dropped; move is unchanged; drop_cnt increments if the feature is enabled.
- Pending release: pending==1 and busy==0 → enter <= 1 for one cycle, pending <= 0.
  - A rise in that same cycle counts as arriving while pending==1 and is dropped.
- enter is registered, never combinational, and never high on two consecutive cycles.
  - Exception: the release of a pending press in the cycle immediately after a direct issue is impossible by construction, since pending only sets when busy is high.
- Latency: raw btn_enter sampled high at edge k and held stable, busy low → db_enter high after edge k+1+DB_CYCLES; enter high during the cycle after edge k+2+DB_CYCLES.
- move reflects db_move, not raw btn_move. Switches must settle DB_CYCLES before pressing enter or the old code is captured.
- busy is sampled synchronously. It is an internal signal and is not synchronised.
- Reset mid-debounce or with a press pending: the press is lost; no enter is issued after reset.

Optional Feature:
- Macro: CORRAL_DROP_CNT_EN.
- Defined:
  - drop_cnt is a 4-bit saturating counter that increments once per dropped press and holds at 15.
  - Cleared only by reset.
- Undefined:
  - drop_cnt is constant 0 and no counter flops are built.
  - All other behaviour is identical.

Test Plan:
Run with DB_CYCLES=4.
- Clean press: btn_move=3'b101 held stable for 10 cycles, then btn_enter high from edge 0 for 20 cycles, busy=0 → enter high only in the cycle after edge 6; move=3'b101; pending stays 0.
- Bounce: btn_enter toggles 1,0,1,0 on alternate cycles, then held high → no enter until 4 stable cycles after the final rise; then exactly one pulse.
- Busy hold: busy=1, press with move=3'b011 → pending=1, enter=0; drop busy after 30 cycles → enter pulses in the next cycle, move=3'b011, pending=0.
- Drop: busy=1, first press with move=3'b001, release, second press with move=3'b110; then busy=0 → one pulse with move=3'b001; drop_cnt=1 with the macro defined, 0 without.
- Saturation (macro defined): one pending press plus 20 further presses while busy → drop_cnt=15.
- Reset mid-operation: pending=1, pulse reset_n low for 1 cycle → all outputs 0 immediately; busy=0 afterwards → no enter pulse.
